// File: rtl/rgmii_pkg.sv
// Shared types for the RGMII clock/reset sequencer: FSM state encoding and output decode.
package rgmii_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        PHY_RST,
        PHY_WAIT,
        RUN,
        FAULT
    } rgmii_seq_state_e;

    typedef struct packed {
        logic pll_rst;
        logic phy_rst_n;
        logic tx_rst;
        logic ready;
    } rgmii_seq_out_t;

    // Output levels held while the sequencer sits in a given state.
    function automatic rgmii_seq_out_t seq_decode(input rgmii_seq_state_e s);
        rgmii_seq_out_t o;
        o = '{pll_rst: 1'b0, phy_rst_n: 1'b0, tx_rst: 1'b1, ready: 1'b0};
        case (s)
            PLL_RST:            o.pll_rst = 1'b1;
            WAIT_LOCK, PHY_RST: o.pll_rst = 1'b0;
            PHY_WAIT:           o.phy_rst_n = 1'b1;
            RUN: begin
                o.phy_rst_n = 1'b1;
                o.tx_rst    = 1'b0;
                o.ready     = 1'b1;
            end
            FAULT:              o.pll_rst = 1'b1;
            default:            o.pll_rst = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rgmii_sync_bit.sv
// N-flop single-bit synchronizer with a synchronous reset value (STAGES must be >= 2).
module rgmii_sync_bit #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rgmii_clk_rst_seq.sv
// PLL / PHY / RGMII-TX reset sequencer on the 70 MHz reference clock.
// Optional retry limit and sticky FAULT state: define RGMII_CLK_RST_SEQ_FAULT_EN.
module rgmii_clk_rst_seq
    import rgmii_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 70,
    parameter int unsigned LOCK_STABLE_CYCLES  = 700,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 70000,
    parameter int unsigned PHY_RST_CYCLES      = 700000,
    parameter int unsigned PHY_WAIT_CYCLES     = 7000,
    parameter int unsigned MAX_RETRIES         = 8
) (
    input  logic clk_70mhz,
    input  logic rst,
    input  logic pll_lock,
    output logic pll_rst,
    output logic phy_rst_n,
    output logic tx_rst,
    output logic ready,
    output logic fault
);

    localparam int unsigned DWELL_MAX_A = (PLL_RST_CYCLES > PHY_RST_CYCLES) ? PLL_RST_CYCLES : PHY_RST_CYCLES;
    localparam int unsigned DWELL_MAX   = (DWELL_MAX_A > PHY_WAIT_CYCLES) ? DWELL_MAX_A : PHY_WAIT_CYCLES;
    localparam int unsigned DWELL_W     = $clog2(DWELL_MAX) + 1;
    localparam int unsigned STABLE_W    = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int unsigned TMO_W       = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

    if (PLL_RST_CYCLES == 0 || LOCK_STABLE_CYCLES == 0 || LOCK_TIMEOUT_CYCLES == 0 ||
        PHY_RST_CYCLES == 0 || PHY_WAIT_CYCLES == 0 || MAX_RETRIES == 0) begin : g_bad_param
        $error("rgmii_clk_rst_seq: cycle counts and MAX_RETRIES must be nonzero");
    end

    rgmii_seq_state_e      state_q, state_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [STABLE_W-1:0]   stable_q, stable_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    rgmii_seq_out_t        out_q;
    logic                  lock_s;

`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES) + 1;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  fault_q;
`endif

    rgmii_sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk_70mhz),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State, counters and outputs; outputs carry the decode of the next state.
    always_ff @(posedge clk_70mhz) begin
        if (rst) begin
            state_q  <= PLL_RST;
            dwell_q  <= '0;
            stable_q <= '0;
            tmo_q    <= '0;
            out_q    <= seq_decode(PLL_RST);
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
            retry_q  <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            stable_q <= stable_d;
            tmo_q    <= tmo_d;
            out_q    <= seq_decode(state_d);
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
            retry_q  <= retry_d;
            fault_q  <= (state_d == FAULT);
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        stable_d = stable_q;
        tmo_d    = tmo_q;
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            PLL_RST: begin
                stable_d = '0;
                tmo_d    = '0;
                if (dwell_q == DWELL_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
                else                                          dwell_d = dwell_q + 1'b1;
            end
            WAIT_LOCK: begin
                if (!lock_s)                                          stable_d = '0;
                else if (stable_q != STABLE_W'(LOCK_STABLE_CYCLES))   stable_d = stable_q + 1'b1;
                if (tmo_q != TMO_W'(LOCK_TIMEOUT_CYCLES))             tmo_d = tmo_q + 1'b1;
                // A stable lock completing on the timeout cycle takes priority.
                if (stable_d == STABLE_W'(LOCK_STABLE_CYCLES)) begin
                    state_d = PHY_RST;
                end else if (tmo_d == TMO_W'(LOCK_TIMEOUT_CYCLES)) begin
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
                    if (retry_q == RETRY_W'(MAX_RETRIES - 1)) begin
                        state_d = FAULT;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + 1'b1;
                    end
`else
                    state_d = PLL_RST;
`endif
                end
            end
            PHY_RST: begin
                if (!lock_s)                                          state_d = PLL_RST;
                else if (dwell_q == DWELL_W'(PHY_RST_CYCLES - 1))     state_d = PHY_WAIT;
                else                                                  dwell_d = dwell_q + 1'b1;
            end
            PHY_WAIT: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                end else if (dwell_q == DWELL_W'(PHY_WAIT_CYCLES - 1)) begin
                    state_d = RUN;
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
                    retry_d = '0;
`endif
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) state_d = PLL_RST;
            end
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
            FAULT:   state_d = FAULT;
`endif
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) dwell_d = '0;
    end

    assign pll_rst   = out_q.pll_rst;
    assign phy_rst_n = out_q.phy_rst_n;
    assign tx_rst    = out_q.tx_rst;
    assign ready     = out_q.ready;
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_clk_rst_seq.sv
// Directed scoreboard bench for rgmii_clk_rst_seq with shortened cycle counts.
module tb_rgmii_clk_rst_seq;

    // Output vector order: {pll_rst, phy_rst_n, tx_rst, ready, fault}
    localparam logic [4:0] O_PLLRST  = 5'b10100;
    localparam logic [4:0] O_WAIT    = 5'b00100;
    localparam logic [4:0] O_PHYWAIT = 5'b01100;
    localparam logic [4:0] O_RUN     = 5'b01010;
`ifdef RGMII_CLK_RST_SEQ_FAULT_EN
    localparam logic [4:0] O_TMO3    = 5'b10101;
    localparam logic [4:0] O_TMO3B   = 5'b10101;
    localparam logic [4:0] O_TOGGLE  = 5'b10101;
`else
    localparam logic [4:0] O_TMO3    = O_PLLRST;
    localparam logic [4:0] O_TMO3B   = O_WAIT;
    localparam logic [4:0] O_TOGGLE  = O_WAIT;
`endif

    typedef struct {
        int unsigned cyc;
        logic [4:0]  outs;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle  = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic pll_lock = 1'b0;
    logic pll_rst, phy_rst_n, tx_rst, ready, fault;

    always #5 clk = ~clk;

    rgmii_clk_rst_seq #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .PHY_RST_CYCLES      (16),
        .PHY_WAIT_CYCLES     (10),
        .MAX_RETRIES         (3)
    ) dut (
        .clk_70mhz (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .phy_rst_n (phy_rst_n),
        .tx_rst    (tx_rst),
        .ready     (ready),
        .fault     (fault)
    );

    task automatic push(input int unsigned dc, input logic [4:0] v, input string tag);
        exp_t e;
        e.cyc  = cycle + dc;
        e.outs = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        logic [4:0] obs;
        obs = {pll_rst, phy_rst_n, tx_rst, ready, fault};
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cycle) begin
                checks++;
                assert (obs === sb[i].outs) else begin
                    errors++;
                    $error("FAIL %s cycle=%0d observed=%b expected=%b", sb[i].tag, cycle, obs, sb[i].outs);
                end
                sb.delete(i);
            end
        end
    endtask

    // Advance n edges; outputs are compared on the falling edge after each rising edge.
    task automatic run(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            cycle++;
            @(negedge clk);
            check_due();
        end
    endtask

    initial begin
        // Reset and nominal bring-up
        push(3, O_PLLRST, "reset_values");
        run(3);
        rst = 1'b0;
        push(3, O_PLLRST, "pll_rst_last");
        push(4, O_WAIT,   "wait_lock_entry");
        run(4);
        pll_lock = 1'b1;
        push(9,  O_WAIT,    "wait_lock_last");
        push(10, O_WAIT,    "phy_rst_entry");
        push(25, O_WAIT,    "phy_rst_last");
        push(26, O_PHYWAIT, "phy_rst_n_rise");
        push(35, O_PHYWAIT, "phy_wait_last");
        push(36, O_RUN,     "ready_rise");
        push(60, O_RUN,     "run_hold");
        run(60);

        // Single-cycle lock loss in RUN
        pll_lock = 1'b0;
        push(2,  O_RUN,     "lock_loss_pre");
        push(3,  O_PLLRST,  "lock_loss");
        push(6,  O_PLLRST,  "lock_loss_pll_last");
        push(7,  O_WAIT,    "lock_loss_rewait");
        push(30, O_WAIT,    "lock_loss_phy_rst_last");
        push(31, O_PHYWAIT, "lock_loss_phy_wait");
        push(40, O_PHYWAIT, "lock_loss_phy_wait_last");
        push(41, O_RUN,     "lock_loss_rerun");
        run(1);
        pll_lock = 1'b1;
        run(41);

        // rst asserted during PHY_WAIT
        pll_lock = 1'b0;
        push(3,  O_PLLRST,  "lock_loss2");
        push(33, O_PHYWAIT, "pre_mid_rst");
        push(34, O_PLLRST,  "mid_rst");
        run(1);
        pll_lock = 1'b1;
        run(32);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        push(3,  O_PLLRST,  "mid_rst_pll_last");
        push(4,  O_WAIT,    "mid_rst_wait");
        push(27, O_WAIT,    "mid_rst_phy_rst_last");
        push(28, O_PHYWAIT, "mid_rst_phy_wait");
        push(38, O_RUN,     "mid_rst_run");
        run(40);

        // Glitchy lock restarts the stable count
        rst = 1'b1;
        pll_lock = 1'b0;
        push(1, O_PLLRST, "glitch_reset");
        run(1);
        rst = 1'b0;
        run(4);
        pll_lock = 1'b1;
        push(17, O_WAIT,    "glitch_still_wait");
        push(26, O_WAIT,    "glitch_restart");
        push(33, O_WAIT,    "glitch_phy_rst_last");
        push(34, O_PHYWAIT, "glitch_phy_wait");
        run(7);
        pll_lock = 1'b0;
        run(1);
        pll_lock = 1'b1;
        run(30);

        // Lock timeout retries
        rst = 1'b1;
        pll_lock = 1'b0;
        run(1);
        rst = 1'b0;
        push(4,   O_WAIT,   "tmo_wait");
        push(35,  O_WAIT,   "tmo_last_wait");
        push(36,  O_PLLRST, "tmo1_pulse");
        push(39,  O_PLLRST, "tmo1_pulse_last");
        push(40,  O_WAIT,   "tmo1_rewait");
        push(72,  O_PLLRST, "tmo2_pulse");
        push(76,  O_WAIT,   "tmo2_rewait");
        push(108, O_TMO3,   "tmo3");
        push(112, O_TMO3B,  "tmo3_after");
        run(113);
        pll_lock = 1'b1;
        push(27, O_TOGGLE, "tmo_lock_toggle");
        run(5);
        pll_lock = 1'b0;
        run(3);
        pll_lock = 1'b1;
        run(20);

        // Stable completes on the final timeout cycle
        rst = 1'b1;
        pll_lock = 1'b0;
        run(1);
        rst = 1'b0;
        push(36, O_WAIT,    "simul_stable_wins");
        push(51, O_WAIT,    "simul_phy_rst_last");
        push(52, O_PHYWAIT, "simul_phy_wait");
        push(62, O_RUN,     "simul_run");
        run(26);
        pll_lock = 1'b1;
        run(40);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
